// File: rtl/exec_monitor.sv
// exec_monitor: execution checker for the 8-bit computer.
// Walks a programmable table of expected events (opcode fetch, accumulator
// value, I/O write), then counts fetches of a loop opcode up to a runtime
// target and reports pass, or fail with a code.
// Optional PC history ring buffer: define EXEC_MONITOR_HISTORY_EN.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; event table writable
// SEQ    | matching table entry ev_idx, timeout running
// LOOP   | counting loop_op fetches toward loop_target, timeout running
// PASS   | sequence and loop completed; held until start or reset
// FAIL   | timeout or I/O data mismatch; fail_code holds the reason
module exec_monitor #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 4,
    parameter int NUM_EVENTS  = 8,
    parameter int LOOP_W      = 16,
    parameter int TIMEOUT_CYC = 65536,
    parameter int HIST_DEPTH  = 8,
    localparam int IDX_W      = $clog2(NUM_EVENTS + 1),
    localparam int HIST_IW    = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1
) (
    input  logic              clk_i,
    input  logic              reset_i,        // active-low, synchronous
    input  logic [DATA_W-1:0] ir_i,
    input  logic              ir_load_i,
    input  logic [DATA_W-1:0] a_reg_i,
    input  logic [7:0]        pc_i,
    input  logic              io_we_i,
    input  logic [ADDR_W-1:0] io_addr_i,
    input  logic [DATA_W-1:0] io_data_i,
    input  logic              cfg_we_i,
    input  logic [IDX_W-1:0]  cfg_idx_i,
    input  logic [1:0]        cfg_kind_i,
    input  logic [DATA_W-1:0] cfg_val_i,
    input  logic [ADDR_W-1:0] cfg_addr_i,
    input  logic [IDX_W-1:0]  seq_len_i,
    input  logic [DATA_W-1:0] loop_op_i,
    input  logic [LOOP_W-1:0] loop_target_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [2:0]        fail_code_o,
    output logic [IDX_W-1:0]  ev_idx_o,
    output logic [LOOP_W-1:0] loop_cnt_o,
    input  logic [HIST_IW-1:0] hist_rd_idx_i,
    output logic [7:0]        hist_pc_o
);

    localparam int TBL_IW = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1;
    localparam int TO_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [IDX_W-1:0] NUM_EV_I = IDX_W'(NUM_EVENTS);
    localparam logic [1:0] KIND_AREG = 2'd1;
    localparam logic [1:0] KIND_IOWR = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEQ  = 3'd1,
        ST_LOOP = 3'd2,
        ST_PASS = 3'd3,
        ST_FAIL = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ev_idx_q, ev_idx_d;
    logic [LOOP_W-1:0]  loop_cnt_q, loop_cnt_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic [2:0]         fail_code_q, fail_code_d;
    logic [IDX_W-1:0]   seq_len_q, seq_len_d;
    logic [DATA_W-1:0]  loop_op_q, loop_op_d;
    logic [LOOP_W-1:0]  loop_target_q, loop_target_d;

    // Event table: deliberately not reset so a board reset keeps the program.
    logic [1:0]         tbl_kind_q [NUM_EVENTS];
    logic [DATA_W-1:0]  tbl_val_q  [NUM_EVENTS];
    logic [ADDR_W-1:0]  tbl_addr_q [NUM_EVENTS];

    logic               busy, start_go;
    logic [1:0]         cur_kind;
    logic [DATA_W-1:0]  cur_val;
    logic [ADDR_W-1:0]  cur_addr;
    logic               io_hit, seq_match, seq_iomis, loop_hit;
    logic [IDX_W-1:0]   ev_inc, seq_len_clamp;
    logic [LOOP_W-1:0]  loop_inc;

    assign busy     = (state_q == ST_SEQ) || (state_q == ST_LOOP);
    assign start_go = start_i && !busy;

    assign cur_kind = tbl_kind_q[ev_idx_q[TBL_IW-1:0]];
    assign cur_val  = tbl_val_q[ev_idx_q[TBL_IW-1:0]];
    assign cur_addr = tbl_addr_q[ev_idx_q[TBL_IW-1:0]];

    // Kind 3 is reserved and falls through to the opcode-fetch check.
    assign io_hit    = io_we_i && (io_addr_i == cur_addr);
    assign seq_match = (cur_kind == KIND_AREG) ? (a_reg_i == cur_val) :
                       (cur_kind == KIND_IOWR) ? (io_hit && (io_data_i == cur_val)) :
                                                 (ir_load_i && (ir_i == cur_val));
    assign seq_iomis = (cur_kind == KIND_IOWR) && io_hit && (io_data_i != cur_val);
    assign loop_hit  = ir_load_i && (ir_i == loop_op_q);

    assign ev_inc        = ev_idx_q + IDX_W'(1);
    assign loop_inc      = (loop_cnt_q == '1) ? loop_cnt_q : loop_cnt_q + LOOP_W'(1);
    assign seq_len_clamp = (seq_len_i > NUM_EV_I) ? NUM_EV_I : seq_len_i;

    // Table writes are only accepted while no check is running.
    always_ff @(posedge clk_i) begin
        if (cfg_we_i && !busy && (cfg_idx_i < NUM_EV_I)) begin
            tbl_kind_q[cfg_idx_i[TBL_IW-1:0]] <= cfg_kind_i;
            tbl_val_q[cfg_idx_i[TBL_IW-1:0]]  <= cfg_val_i;
            tbl_addr_q[cfg_idx_i[TBL_IW-1:0]] <= cfg_addr_i;
        end
    end

    // Next-state, counters and fail code; a match always beats a timeout.
    always_comb begin
        state_d       = state_q;
        ev_idx_d      = ev_idx_q;
        loop_cnt_d    = loop_cnt_q;
        to_cnt_d      = to_cnt_q;
        fail_code_d   = fail_code_q;
        seq_len_d     = seq_len_q;
        loop_op_d     = loop_op_q;
        loop_target_d = loop_target_q;
        case (state_q)
            ST_IDLE, ST_PASS, ST_FAIL: begin
                if (start_i) begin
                    seq_len_d     = seq_len_clamp;
                    loop_op_d     = loop_op_i;
                    loop_target_d = loop_target_i;
                    ev_idx_d      = '0;
                    loop_cnt_d    = '0;
                    to_cnt_d      = '0;
                    fail_code_d   = 3'd0;
                    state_d       = (seq_len_clamp == '0) ? ST_LOOP : ST_SEQ;
                end
            end
            ST_SEQ: begin
                if (seq_match) begin
                    ev_idx_d = ev_inc;
                    to_cnt_d = '0;
                    if (ev_inc == seq_len_q) state_d = ST_LOOP;
                end else if (seq_iomis) begin
                    fail_code_d = 3'd2;
                    state_d     = ST_FAIL;
                end else if (to_cnt_q == TO_LAST) begin
                    fail_code_d = 3'd1;
                    state_d     = ST_FAIL;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            ST_LOOP: begin
                if (loop_target_q == '0) begin
                    state_d = ST_PASS;
                end else if (loop_hit) begin
                    loop_cnt_d = loop_inc;
                    to_cnt_d   = '0;
                    if (loop_inc == loop_target_q) state_d = ST_PASS;
                end else if (to_cnt_q == TO_LAST) begin
                    fail_code_d = 3'd3;
                    state_d     = ST_FAIL;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and status registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q       <= ST_IDLE;
            ev_idx_q      <= '0;
            loop_cnt_q    <= '0;
            to_cnt_q      <= '0;
            fail_code_q   <= 3'd0;
            seq_len_q     <= '0;
            loop_op_q     <= '0;
            loop_target_q <= '0;
        end else begin
            state_q       <= state_d;
            ev_idx_q      <= ev_idx_d;
            loop_cnt_q    <= loop_cnt_d;
            to_cnt_q      <= to_cnt_d;
            fail_code_q   <= fail_code_d;
            seq_len_q     <= seq_len_d;
            loop_op_q     <= loop_op_d;
            loop_target_q <= loop_target_d;
        end
    end

    assign busy_o      = busy;
    assign done_o      = (state_q == ST_PASS) || (state_q == ST_FAIL);
    assign pass_o      = (state_q == ST_PASS);
    assign fail_code_o = fail_code_q;
    assign ev_idx_o    = ev_idx_q;
    assign loop_cnt_o  = loop_cnt_q;

`ifdef EXEC_MONITOR_HISTORY_EN
    // Pointer arithmetic wraps naturally, so HIST_DEPTH should be a power of two.
    logic [7:0]         hist_q [HIST_DEPTH];
    logic [HIST_IW-1:0] hist_wp_q;
    logic [7:0]         hist_pc_q;

    // Record PC per fetch while busy; freezes once FAIL is entered, cleared by start.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            hist_wp_q <= '0;
            hist_pc_q <= 8'd0;
        end else begin
            if (start_go) begin
                hist_wp_q <= '0;
                for (int i = 0; i < HIST_DEPTH; i++) hist_q[i] <= 8'd0;
            end else if (busy && ir_load_i) begin
                hist_q[hist_wp_q] <= pc_i;
                hist_wp_q         <= hist_wp_q + HIST_IW'(1);
            end
            hist_pc_q <= hist_q[hist_wp_q - HIST_IW'(1) - hist_rd_idx_i];
        end
    end

    assign hist_pc_o = hist_pc_q;
`else
    logic unused_hist;
    assign unused_hist = ^{pc_i, hist_rd_idx_i, start_go};
    assign hist_pc_o   = 8'd0;
`endif

endmodule
